cafe_vend_controller: RTL and testbench

Sequencing controller for the cafe vending machine. It accepts coin events, accumulates credit against a programmable price, and runs a req/ack handshake with the product dispenser. It then pays out change or refunds one coin at a time through a coin-hopper handshake. It sits between the coin acceptor front end and the dispenser/hopper actuators.

---
 rtl/cafe_pkg.sv | 31 +++
 rtl/cafe_vend_controller_if.sv | 24 ++
 rtl/cafe_change_payout.sv | 46 ++++
 rtl/cafe_vend_controller.sv | 143 ++++++++++++++
 tb/tb_cafe_vend_controller.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cafe_pkg.sv
// Shared coin encodings, values and controller state type for the cafe vending slice.
package cafe_pkg;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  localparam int VAL_NICKEL  = 5;
  localparam int VAL_DIME    = 10;
  localparam int VAL_QUARTER = 25;

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  function automatic logic [4:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_NICKEL:  coin_value = 5'(VAL_NICKEL);
      COIN_DIME:    coin_value = 5'(VAL_DIME);
      COIN_QUARTER: coin_value = 5'(VAL_QUARTER);
      default:      coin_value = 5'd0;
    endcase
  endfunction

  // Largest coin that does not exceed the amount still owed.
  function automatic logic [1:0] greedy_coin(input int amt);
    if (amt >= VAL_QUARTER)   greedy_coin = COIN_QUARTER;
    else if (amt >= VAL_DIME) greedy_coin = COIN_DIME;
    else                      greedy_coin = COIN_NICKEL;
  endfunction

endpackage

// File: rtl/cafe_vend_controller_if.sv
// Coin acceptor, dispenser and hopper signals seen by the vend controller.
interface cafe_vend_controller_if #(parameter int CW = 7);
  logic          coin_valid;
  logic [1:0]    coin;
  logic          coin_ready;
  logic          cancel;
  logic          vend_req;
  logic          vend_ack;
  logic          pay_valid;
  logic [1:0]    pay_coin;
  logic          pay_ack;
  logic [CW-1:0] credit;
  logic          busy;

  modport slave (
    input  coin_valid, coin, cancel, vend_ack, pay_ack,
    output coin_ready, vend_req, pay_valid, pay_coin, credit, busy
  );

  modport master (
    output coin_valid, coin, cancel, vend_ack, pay_ack,
    input  coin_ready, vend_req, pay_valid, pay_coin, credit, busy
  );
endinterface

// File: rtl/cafe_change_payout.sv
// Greedy change engine: ejects one coin per hopper ack until the loaded amount is paid.
module cafe_change_payout
  import cafe_pkg::*;
#(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] amount,
    input  logic          pay_ack,
    output logic          pay_valid,
    output logic [1:0]    pay_coin,
    output logic [CW-1:0] remaining,
    output logic          done
);

    logic [CW-1:0] rem_q;
    logic [CW-1:0] rem_next;
    logic          valid_q;
    logic [1:0]    coin_q;

    assign rem_next  = rem_q - CW'(coin_value(coin_q));
    assign done      = valid_q & pay_ack & (rem_next == '0);
    assign pay_valid = valid_q;
    assign pay_coin  = coin_q;
    assign remaining = rem_q;

    // pay_coin is only recomputed on load or ack, so it is stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            valid_q <= 1'b0;
            coin_q  <= COIN_NONE;
        end else if (load) begin
            rem_q   <= amount;
            valid_q <= (amount != '0);
            coin_q  <= (amount != '0) ? greedy_coin(int'(amount)) : COIN_NONE;
        end else if (valid_q && pay_ack) begin
            rem_q   <= rem_next;
            valid_q <= (rem_next != '0);
            coin_q  <= (rem_next != '0) ? greedy_coin(int'(rem_next)) : COIN_NONE;
        end
    end

endmodule

// File: rtl/cafe_vend_controller.sv
// Credit collection, vend handshake and change/refund sequencing for the cafe vending machine.
module cafe_vend_controller
  import cafe_pkg::*;
#(
    parameter int PRICE   = 50,
    parameter int TIMEOUT = 255,
    parameter int CW      = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    cafe_vend_controller_if.slave  bus
);

    localparam int            TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] credit_q;
    logic [TW-1:0] timer;
    logic          coin_ready_q, vend_req_q, busy_q;

    logic          acc;
    logic [CW-1:0] coin_amt, sum, vend_rem;
    logic          load;
    logic [CW-1:0] load_amt;
    logic          pay_valid, pay_done;
    logic [1:0]    pay_coin;
    logic [CW-1:0] remaining;

    assign acc      = bus.coin_valid & coin_ready_q & (bus.coin != COIN_NONE);
    assign coin_amt = acc ? CW'(coin_value(bus.coin)) : '0;
    assign sum      = credit_q + coin_amt;
    assign vend_rem = credit_q - PRICE_C;

    // The payout engine is loaded on the transition edge so pay_valid rises on CHANGE entry.
    always_comb begin
        load     = 1'b0;
        load_amt = '0;
        case (state)
            COLLECT: begin
                if (!(acc && sum >= PRICE_C) &&
                    (bus.cancel || (!acc && timer == TO_LAST))) begin
                    load     = 1'b1;
                    load_amt = sum;
                end
            end
            VEND: begin
                if (bus.vend_ack && vend_rem != '0) begin
                    load     = 1'b1;
                    load_amt = vend_rem;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credit_q     <= '0;
            timer        <= '0;
            coin_ready_q <= 1'b1;
            vend_req_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        credit_q <= sum;
                        timer    <= '0;
                        if (sum >= PRICE_C) begin
                            state        <= VEND;
                            coin_ready_q <= 1'b0;
                            vend_req_q   <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    credit_q <= sum;
                    if (acc && sum >= PRICE_C) begin
                        state        <= VEND;
                        coin_ready_q <= 1'b0;
                        vend_req_q   <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (load) begin
                        state        <= CHANGE;
                        coin_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end else begin
                        timer <= acc ? '0 : timer + 1'b1;
                    end
                end
                VEND: begin
                    if (bus.vend_ack) begin
                        vend_req_q <= 1'b0;
                        credit_q   <= vend_rem;
                        if (vend_rem == '0) begin
                            state        <= IDLE;
                            coin_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end else begin
                            state <= CHANGE;
                        end
                    end
                end
                CHANGE: begin
                    if (pay_done) begin
                        state        <= IDLE;
                        credit_q     <= '0;
                        timer        <= '0;
                        coin_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cafe_change_payout #(.CW(CW)) u_payout (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .amount    (load_amt),
        .pay_ack   (bus.pay_ack),
        .pay_valid (pay_valid),
        .pay_coin  (pay_coin),
        .remaining (remaining),
        .done      (pay_done)
    );

    assign bus.coin_ready = coin_ready_q;
    assign bus.vend_req   = vend_req_q;
    assign bus.busy       = busy_q;
    assign bus.pay_valid  = pay_valid;
    assign bus.pay_coin   = pay_coin;
    assign bus.credit     = (state == CHANGE) ? remaining : credit_q;

endmodule

// File: tb/tb_cafe_vend_controller.sv
// Directed scoreboard bench: stimulus queues expected vend/pay handshakes, a monitor checks them.
module tb_cafe_vend_controller;
  import cafe_pkg::*;

  localparam int CW = 7;

  typedef struct {
    int kind;   // 0 vend, 1 pay
    int coin;
    int credit;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;

  cafe_vend_controller_if #(.CW(CW)) bus ();

  cafe_vend_controller #(.PRICE(50), .TIMEOUT(8), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] c, input logic canc);
    bus.coin_valid = 1'b1;
    bus.coin       = c;
    bus.cancel     = canc;
    tick();
    bus.coin_valid = 1'b0;
    bus.coin       = COIN_NONE;
    bus.cancel     = 1'b0;
  endtask

  task automatic exp_vend(input int cr);
    ev_t e;
    e.kind = 0; e.coin = 0; e.credit = cr;
    exp_q.push_back(e);
  endtask

  task automatic exp_pay(input logic [1:0] c, input int cr);
    ev_t e;
    e.kind = 1; e.coin = int'(c); e.credit = cr;
    exp_q.push_back(e);
  endtask

  task automatic vend(input int hold);
    int n = 0;
    while (!bus.vend_req && n < 20) begin tick(); n++; end
    chk("vend_req seen", 32'(bus.vend_req), 1);
    if (!bus.vend_req) return;
    for (int i = 0; i < hold; i++) begin
      chk("vend_req held", 32'(bus.vend_req), 1);
      tick();
    end
    bus.vend_ack = 1'b1;
    tick();
    bus.vend_ack = 1'b0;
  endtask

  task automatic pay(input int hold, input logic [1:0] c);
    int n = 0;
    while (!bus.pay_valid && n < 20) begin tick(); n++; end
    chk("pay_valid seen", 32'(bus.pay_valid), 1);
    if (!bus.pay_valid) return;
    for (int i = 0; i < hold; i++) begin
      chk("pay_coin stable", 32'(bus.pay_coin), 32'(c));
      tick();
    end
    bus.pay_ack = 1'b1;
    tick();
    bus.pay_ack = 1'b0;
  endtask

  // Monitor: every completed handshake must match the head of the scoreboard.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && ((bus.vend_req && bus.vend_ack) || (bus.pay_valid && bus.pay_ack))) begin
        if (exp_q.size() == 0) begin
          chk("unexpected handshake", 32'(bus.credit), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("event kind", (bus.pay_valid && bus.pay_ack) ? 32'd1 : 32'd0, 32'(e.kind));
          chk("event credit", 32'(bus.credit), 32'(e.credit));
          if (e.kind == 1) chk("event coin", 32'(bus.pay_coin), 32'(e.coin));
        end
      end
    end
  end

  initial begin
    bus.coin_valid = 1'b0;
    bus.coin       = COIN_NONE;
    bus.cancel     = 1'b0;
    bus.vend_ack   = 1'b0;
    bus.pay_ack    = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst coin_ready", 32'(bus.coin_ready), 1);
    chk("rst vend_req", 32'(bus.vend_req), 0);
    chk("rst pay_valid", 32'(bus.pay_valid), 0);
    chk("rst pay_coin", 32'(bus.pay_coin), 0);
    chk("rst credit", 32'(bus.credit), 0);
    chk("rst busy", 32'(bus.busy), 0);

    // Stray ack and idle cancel are ignored
    bus.vend_ack = 1'b1; bus.pay_ack = 1'b1; bus.cancel = 1'b1;
    tick();
    bus.vend_ack = 1'b0; bus.pay_ack = 1'b0; bus.cancel = 1'b0;
    chk("stray ack coin_ready", 32'(bus.coin_ready), 1);
    chk("stray ack pay_valid", 32'(bus.pay_valid), 0);

    // Exact price: quarter + quarter, vend_ack on the third vend_req cycle
    put_coin(COIN_QUARTER, 1'b0);
    chk("exact credit 25", 32'(bus.credit), 25);
    put_coin(COIN_QUARTER, 1'b0);
    chk("exact vend_req", 32'(bus.vend_req), 1);
    chk("exact busy", 32'(bus.busy), 1);
    chk("exact coin_ready", 32'(bus.coin_ready), 0);
    exp_vend(50);
    vend(2);
    chk("exact credit 0", 32'(bus.credit), 0);
    chk("exact vend_req low", 32'(bus.vend_req), 0);
    tick();
    chk("exact no pay", 32'(bus.pay_valid), 0);
    chk("exact idle ready", 32'(bus.coin_ready), 1);

    // Overpay 65: change 15 as dime then nickel
    repeat (4) put_coin(COIN_DIME, 1'b0);
    put_coin(COIN_QUARTER, 1'b0);
    exp_vend(65);
    vend(0);
    chk("overpay first pay_valid", 32'(bus.pay_valid), 1);
    chk("overpay credit 15", 32'(bus.credit), 15);
    chk("overpay coin dime", 32'(bus.pay_coin), 32'(COIN_DIME));
    exp_pay(COIN_DIME, 15);
    exp_pay(COIN_NICKEL, 5);
    pay(0, COIN_DIME);
    chk("overpay credit 5", 32'(bus.credit), 5);
    pay(0, COIN_NICKEL);
    chk("overpay credit 0", 32'(bus.credit), 0);
    chk("overpay pay_valid low", 32'(bus.pay_valid), 0);
    chk("overpay idle ready", 32'(bus.coin_ready), 1);

    // Cancel together with a coin: refund 30 as quarter then nickel
    put_coin(COIN_NICKEL, 1'b0);
    put_coin(COIN_DIME, 1'b0);
    put_coin(COIN_DIME, 1'b0);
    put_coin(COIN_NICKEL, 1'b1);
    chk("cancel pay_valid", 32'(bus.pay_valid), 1);
    chk("cancel credit 30", 32'(bus.credit), 30);
    chk("cancel no vend", 32'(bus.vend_req), 0);
    exp_pay(COIN_QUARTER, 30);
    exp_pay(COIN_NICKEL, 5);
    pay(0, COIN_QUARTER);
    pay(0, COIN_NICKEL);
    chk("cancel idle ready", 32'(bus.coin_ready), 1);

    // Cancel on the price-reaching coin: vend wins
    put_coin(COIN_QUARTER, 1'b0);
    put_coin(COIN_QUARTER, 1'b1);
    chk("cancel+price vend_req", 32'(bus.vend_req), 1);
    chk("cancel+price no pay", 32'(bus.pay_valid), 0);
    exp_vend(50);
    vend(0);
    tick();
    chk("cancel+price still no pay", 32'(bus.pay_valid), 0);
    chk("cancel+price credit 0", 32'(bus.credit), 0);

    // Timeout (8): dime then silence
    put_coin(COIN_DIME, 1'b0);
    repeat (7) tick();
    chk("timeout not yet", 32'(bus.pay_valid), 0);
    tick();
    chk("timeout pay_valid", 32'(bus.pay_valid), 1);
    chk("timeout busy", 32'(bus.busy), 1);
    chk("timeout coin dime", 32'(bus.pay_coin), 32'(COIN_DIME));
    exp_pay(COIN_DIME, 10);
    pay(0, COIN_DIME);
    chk("timeout idle ready", 32'(bus.coin_ready), 1);

    // Backpressure: 70 credited, change 20 = dime, dime; coins refused in CHANGE
    put_coin(COIN_QUARTER, 1'b0);
    put_coin(COIN_DIME, 1'b0);
    put_coin(COIN_DIME, 1'b0);
    put_coin(COIN_QUARTER, 1'b0);
    exp_vend(70);
    vend(0);
    chk("bp credit 20", 32'(bus.credit), 20);
    chk("bp coin_ready low", 32'(bus.coin_ready), 0);
    put_coin(COIN_QUARTER, 1'b0);
    chk("bp coin ignored", 32'(bus.credit), 20);
    exp_pay(COIN_DIME, 20);
    exp_pay(COIN_DIME, 10);
    pay(4, COIN_DIME);
    chk("bp credit 10", 32'(bus.credit), 10);
    pay(0, COIN_DIME);
    chk("bp pay_valid low", 32'(bus.pay_valid), 0);

    // Reset mid-payout with 15 outstanding
    repeat (4) put_coin(COIN_DIME, 1'b0);
    put_coin(COIN_QUARTER, 1'b0);
    exp_vend(65);
    vend(0);
    chk("midrst credit 15", 32'(bus.credit), 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst credit 0", 32'(bus.credit), 0);
    chk("midrst pay_valid", 32'(bus.pay_valid), 0);
    chk("midrst coin_ready", 32'(bus.coin_ready), 1);
    chk("midrst busy", 32'(bus.busy), 0);

    tick(); tick();
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
